// File: rtl/debounce_pkg.sv
// Shared definitions for the debounce_sync block.
//   state_e        : FSM state encoding (2 bits)
//   StableDefault  : default qualification length in synchronized cycles
//   cnt_width()    : width of a counter that must hold 0..stable
package debounce_pkg;

  typedef enum logic [1:0] {
    IdleLo = 2'b00,
    ChkHi  = 2'b01,
    IdleHi = 2'b10,
    ChkLo  = 2'b11
  } state_e;

  localparam int unsigned StableDefault = 4;

  function automatic int unsigned cnt_width(int unsigned stable);
    return $clog2(stable + 1);
  endfunction

endpackage

// File: rtl/sync2.sv
// Two-flop synchronizer for a single asynchronous bit.
//   clk : sampling clock
//   rst : asynchronous active-low reset, loads RST_LVL into both stages
//   d   : asynchronous input
//   q   : synchronized output (second stage)
module sync2 #(
  parameter logic RST_LVL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic s1_q;
  logic s2_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1_q <= RST_LVL;
      s2_q <= RST_LVL;
    end else begin
      s1_q <= d;
      s2_q <= s1_q;
    end
  end

  assign q = s2_q;

endmodule

// File: rtl/debounce_sync.sv
// Synchronizing debouncer. A new level on din is accepted once the synchronized
// input has held it for STABLE+1 consecutive cycles; any return to the current
// level during qualification drops the candidate.
//   clk  : clock
//   rst  : asynchronous active-low reset
//   din  : raw asynchronous input
//   dout : registered debounced level
//   rise : registered one-cycle pulse when dout goes to 1
//   fall : registered one-cycle pulse when dout goes to 0
//   busy : a candidate transition is being qualified
module debounce_sync
  import debounce_pkg::*;
#(
  parameter int unsigned STABLE  = StableDefault,
  parameter logic        RST_LVL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic dout,
  output logic rise,
  output logic fall,
  output logic busy
);

  localparam int unsigned CntW = cnt_width(STABLE);
  localparam logic [CntW-1:0] StableCnt = CntW'(STABLE);
  localparam logic [CntW-1:0] OneCnt    = CntW'(1);
  localparam state_e RstState = RST_LVL ? IdleHi : IdleLo;

  logic s2;

  sync2 #(
    .RST_LVL (RST_LVL)
  ) u_sync2 (
    .clk (clk),
    .rst (rst),
    .d   (din),
    .q   (s2)
  );

  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            dout_q, dout_d;
  logic            rise_q, rise_d;
  logic            fall_q, fall_d;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= RstState;
      cnt_q   <= '0;
      dout_q  <= RST_LVL;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      dout_q  <= dout_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    dout_d  = dout_q;
    rise_d  = 1'b0;
    fall_d  = 1'b0;
    unique case (state_q)
      IdleLo: begin
        if (s2) begin
          state_d = ChkHi;
          cnt_d   = OneCnt;
        end else begin
          cnt_d   = '0;
        end
      end
      ChkHi: begin
        if (!s2) begin
          state_d = IdleLo;
          cnt_d   = '0;
        end else if (cnt_q < StableCnt) begin
          cnt_d   = cnt_q + OneCnt;
        end else begin
          state_d = IdleHi;
          cnt_d   = '0;
          dout_d  = 1'b1;
          rise_d  = 1'b1;
        end
      end
      IdleHi: begin
        if (!s2) begin
          state_d = ChkLo;
          cnt_d   = OneCnt;
        end else begin
          cnt_d   = '0;
        end
      end
      ChkLo: begin
        if (s2) begin
          state_d = IdleHi;
          cnt_d   = '0;
        end else if (cnt_q < StableCnt) begin
          cnt_d   = cnt_q + OneCnt;
        end else begin
          state_d = IdleLo;
          cnt_d   = '0;
          dout_d  = 1'b0;
          fall_d  = 1'b1;
        end
      end
      default: begin
        state_d = RstState;
        cnt_d   = '0;
      end
    endcase
  end

  assign dout = dout_q;
  assign rise = rise_q;
  assign fall = fall_q;
  // Decoded from the state register only, so no path from din.
  assign busy = (state_q == ChkHi) || (state_q == ChkLo);

endmodule
